pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 1, range 1..4: cycles of IF/ID flush per taken branch.
REQ-002 SHALL have parameter MAX_WAIT, default 255, range 1..255: memory-wait cycles allowed before timeout.
REQ-003 clk  in  1  single clock; all state on posedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 IDEX_MemRead  in  1  instruction in EX is a load.
REQ-006 IDEX_Rt  in  5  load destination register.
REQ-007 IFID_Rs, IFID_Rt  in  5 each  source registers of instruction in ID.
REQ-008 Branch_Taken  in  1  taken branch resolved in EX this cycle.
REQ-009 Mem_Busy  in  1  data memory cannot complete this cycle.
REQ-010 PC_WriteEn, IFID_WriteEn, IDEX_WriteEn, EXMEM_WriteEn  out  1 each  stage-register load enables.
REQ-011 IFID_Flush  out  1  load NOP into IF/ID; IDEX_Bubble  out  1  load NOP into ID/EX.
REQ-012 Wait_Timeout  out  1  sticky memory-wait timeout error.

Function
REQ-013 States SHALL be RUN, FLUSH, MEM_WAIT, ERROR; state registered; outputs decoded from state and current inputs.
REQ-014 Load-use hazard (LU) SHALL be IDEX_MemRead && IDEX_Rt!=0 && (IDEX_Rt==IFID_Rs || IDEX_Rt==IFID_Rt).
REQ-015 Default in RUN with no event: all four WriteEn=1, IFID_Flush=0, IDEX_Bubble=0; stay RUN.
REQ-016 Priority in RUN SHALL be Mem_Busy > Branch_Taken > LU.
REQ-017 RUN, Mem_Busy=1: all WriteEn=0, flush/bubble=0, load wait counter with 1, next MEM_WAIT.
REQ-018 RUN, Branch_Taken=1: PC_WriteEn=1, IFID_Flush=1, IDEX_Bubble=1, other WriteEn=1; next RUN if FLUSH_CYCLES=1, else FLUSH with flush counter = FLUSH_CYCLES-1.
REQ-019 RUN, LU=1: PC_WriteEn=0, IFID_WriteEn=0, IDEX_Bubble=1, IDEX_WriteEn=1, EXMEM_WriteEn=1; stay RUN (exactly one bubble per load-use).
REQ-020 FLUSH, Mem_Busy=0: same outputs as REQ-018, counter decrements; at counter 1 next RUN.
REQ-021 FLUSH, Mem_Busy=1: all outputs 0, counter frozen, stay FLUSH; Branch_Taken and LU ignored in FLUSH.
REQ-022 MEM_WAIT, Mem_Busy=1: all outputs 0, wait counter increments; counter reaching MAX_WAIT SHALL go ERROR next cycle.
REQ-023 MEM_WAIT, Mem_Busy=0: outputs evaluated as in RUN (REQ-015..019, Branch_Taken/LU honored), next state as from RUN; wait counter cleared.
REQ-024 ERROR: all WriteEn=0, flush/bubble=0, Wait_Timeout=1; exit only via reset.
REQ-025 Wait counter SHALL be 8 bits, never wrap; flush counter 2 bits.

Reset
REQ-026 While rst=0 all outputs SHALL be 0 (including Wait_Timeout), state RUN, counters 0.
REQ-027 Reset asserted mid-FLUSH, MEM_WAIT or ERROR SHALL abandon the operation immediately; first edge after release evaluates RUN.

Configuration
REQ-028 Macro PIPE_STALL_CNT_EN defined: add output Stall_Count (16 bits), incremented each cycle PC_WriteEn=0 outside reset, saturating at 16'hFFFF, reset 0.
REQ-029 Macro undefined: Stall_Count port and counter SHALL not exist; other behaviour identical.

Structure
REQ-030 Shared package pipe_ctrl_pkg SHALL hold state encoding constants, REG_IDX_W=5, WAIT_CNT_W=8.
REQ-031 Sub-module load_use_detect (combinational, REQ-014) SHALL be instantiated once.

Verification
REQ-032 IDEX_MemRead=1, IDEX_Rt=8, IFID_Rs=8 in RUN -> one cycle PC_WriteEn=0, IFID_WriteEn=0, IDEX_Bubble=1; IDEX_Rt=0 same case -> no stall.
REQ-033 FLUSH_CYCLES=3, Branch_Taken pulse -> IFID_Flush=1 for exactly 3 cycles; Mem_Busy=1 in 2nd -> flush extends to 4 cycles total elapsed, 3 asserted.
REQ-034 Mem_Busy=1 for 5 cycles, then 0 -> all WriteEn=0 for 5 cycles, then 1; Wait_Timeout stays 0.
REQ-035 MAX_WAIT=4, Mem_Busy held 1 -> ERROR after 5th busy cycle, Wait_Timeout=1 until rst=0.
REQ-036 Branch_Taken=1 and LU=1 with Mem_Busy=1 same cycle -> MEM_WAIT; on release branch flush taken, no LU bubble.
REQ-037 With PIPE_STALL_CNT_EN, REQ-034 stimulus -> Stall_Count=5; rst=0 mid-MEM_WAIT -> outputs 0 asynchronously.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: controller state
// encoding, register-index and counter widths, and the decoded control word.
package pipe_ctrl_pkg;

  localparam int REG_IDX_W   = 5;
  localparam int WAIT_CNT_W  = 8;
  localparam int FLUSH_CNT_W = 2;
  localparam int STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERROR    = 2'd3
  } ctrl_state_t;

  // Stage-register controls, in one word so each pipeline action is a constant.
  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic idex_we;
    logic exmem_we;
    logic ifid_flush;
    logic idex_bubble;
  } ctrl_out_t;

  // Normal advance: every stage loads, nothing squashed.
  localparam ctrl_out_t OUT_RUN    = 6'b1111_00;
  // Taken branch: keep fetching the target, squash the wrong-path IF/ID and ID/EX.
  localparam ctrl_out_t OUT_BRANCH = 6'b1111_11;
  // Load-use: hold PC and IF/ID, drop one bubble into ID/EX.
  localparam ctrl_out_t OUT_LU     = 6'b0011_01;
  // Full freeze (memory wait, error, reset).
  localparam ctrl_out_t OUT_HOLD   = 6'b0000_00;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: the load in EX writes a register
// the instruction in ID reads. Register 0 is hard-wired and never a hazard.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic                 idex_mem_read,
  input  logic [REG_IDX_W-1:0] idex_rt,
  input  logic [REG_IDX_W-1:0] ifid_rs,
  input  logic [REG_IDX_W-1:0] ifid_rt,
  output logic                 load_use
);

  assign load_use = idex_mem_read && (idex_rt != '0) &&
                    ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stalls on load-use, flushes on taken branches,
// freezes during data-memory waits and latches a sticky timeout error.
// Optional build macro PIPE_STALL_CNT_EN adds a saturating 16-bit Stall_Count
// of cycles in which the PC was held.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,   // 1..4
  parameter int MAX_WAIT     = 255  // 1..255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 IDEX_MemRead,
  input  logic [REG_IDX_W-1:0] IDEX_Rt,
  input  logic [REG_IDX_W-1:0] IFID_Rs,
  input  logic [REG_IDX_W-1:0] IFID_Rt,
  input  logic                 Branch_Taken,
  input  logic                 Mem_Busy,
  output logic                 PC_WriteEn,
  output logic                 IFID_WriteEn,
  output logic                 IDEX_WriteEn,
  output logic                 EXMEM_WriteEn,
  output logic                 IFID_Flush,
  output logic                 IDEX_Bubble,
  output logic                 Wait_Timeout
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] Stall_Count
`endif
);

  localparam logic [WAIT_CNT_W-1:0]  WAIT_LIMIT = WAIT_CNT_W'(MAX_WAIT);
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  ctrl_state_t             state, state_nxt;
  logic [WAIT_CNT_W-1:0]   wait_cnt, wait_nxt;
  logic [FLUSH_CNT_W-1:0]  flush_cnt, flush_nxt;
  ctrl_out_t               ctrl;
  logic                    timeout;
  logic                    load_use;

  load_use_detect u_load_use (
    .idex_mem_read (IDEX_MemRead),
    .idex_rt       (IDEX_Rt),
    .ifid_rs       (IFID_Rs),
    .ifid_rt       (IFID_Rt),
    .load_use      (load_use)
  );

  // State and counter registers; reset abandons any flush, wait or error.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RUN;
      wait_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      flush_cnt <= flush_nxt;
    end
  end

  // Next-state and output decode; priority Mem_Busy > Branch_Taken > load-use.
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    flush_nxt = flush_cnt;
    ctrl      = OUT_HOLD;
    timeout   = 1'b0;

    case (state)
      // A finished memory wait is evaluated exactly like a fresh RUN cycle.
      ST_RUN, ST_MEM_WAIT: begin
        if (Mem_Busy) begin
          if (state == ST_RUN) begin
            wait_nxt  = WAIT_CNT_W'(1);
            state_nxt = ST_MEM_WAIT;
          end else if (wait_cnt >= WAIT_LIMIT) begin
            state_nxt = ST_ERROR;
          end else begin
            wait_nxt = wait_cnt + WAIT_CNT_W'(1);
          end
        end else begin
          wait_nxt  = '0;
          state_nxt = ST_RUN;
          if (Branch_Taken) begin
            ctrl = OUT_BRANCH;
            if (FLUSH_CYCLES > 1) begin
              state_nxt = ST_FLUSH;
              flush_nxt = FLUSH_INIT;
            end
          end else if (load_use) begin
            ctrl = OUT_LU;
          end else begin
            ctrl = OUT_RUN;
          end
        end
      end

      // Remaining flush cycles; a memory stall freezes the countdown.
      ST_FLUSH: begin
        if (!Mem_Busy) begin
          ctrl = OUT_BRANCH;
          if (flush_cnt <= FLUSH_CNT_W'(1)) begin
            flush_nxt = '0;
            state_nxt = ST_RUN;
          end else begin
            flush_nxt = flush_cnt - FLUSH_CNT_W'(1);
          end
        end
      end

      ST_ERROR: timeout = 1'b1;

      default: state_nxt = ST_RUN;
    endcase

    // Outputs are forced low for as long as reset is held, independent of clk.
    if (!rst) begin
      ctrl    = OUT_HOLD;
      timeout = 1'b0;
    end
  end

  assign PC_WriteEn    = ctrl.pc_we;
  assign IFID_WriteEn  = ctrl.ifid_we;
  assign IDEX_WriteEn  = ctrl.idex_we;
  assign EXMEM_WriteEn = ctrl.exmem_we;
  assign IFID_Flush    = ctrl.ifid_flush;
  assign IDEX_Bubble   = ctrl.idex_bubble;
  assign Wait_Timeout  = timeout;

`ifdef PIPE_STALL_CNT_EN
  // Count cycles with the PC held, saturating rather than wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Stall_Count <= '0;
    end else if (!PC_WriteEn && (Stall_Count != {STALL_CNT_W{1'b1}})) begin
      Stall_Count <= Stall_Count + STALL_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl. Two instances share the stimulus:
// u_dut_a (FLUSH_CYCLES=3, MAX_WAIT=5) and u_dut_b (FLUSH_CYCLES=1, MAX_WAIT=4).
// Each directed vector carries its hand-computed expected control word and
// selects which instance it is checked against.
module tb_pipe_hazard_ctrl;

  // Expected word order: {PC, IFID, IDEX, EXMEM WriteEn, IFID_Flush, IDEX_Bubble, Wait_Timeout}
  localparam logic [6:0] E_RUN  = 7'b1111_00_0;
  localparam logic [6:0] E_BR   = 7'b1111_11_0;
  localparam logic [6:0] E_LU   = 7'b0011_01_0;
  localparam logic [6:0] E_ZERO = 7'b0000_00_0;
  localparam logic [6:0] E_ERR  = 7'b0000_00_1;

  typedef struct {
    logic       sel;
    logic [6:0] exp;
    int         sc;
    string      name;
  } sb_entry_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mr = 1'b0;
  logic [4:0] ex_rt = '0, rs = '0, rt = '0;
  logic       br = 1'b0, busy = 1'b0;

  logic a_pc, a_ifid, a_idex, a_exmem, a_flush, a_bubble, a_to;
  logic b_pc, b_ifid, b_idex, b_exmem, b_flush, b_bubble, b_to;
`ifdef PIPE_STALL_CNT_EN
  logic [15:0] sc_a, sc_b;
`endif

  sb_entry_t sb_q[$];
  sb_entry_t cur;
  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(3), .MAX_WAIT(5)) u_dut_a (
    .clk(clk), .rst(rst), .IDEX_MemRead(mr), .IDEX_Rt(ex_rt), .IFID_Rs(rs), .IFID_Rt(rt),
    .Branch_Taken(br), .Mem_Busy(busy),
    .PC_WriteEn(a_pc), .IFID_WriteEn(a_ifid), .IDEX_WriteEn(a_idex), .EXMEM_WriteEn(a_exmem),
    .IFID_Flush(a_flush), .IDEX_Bubble(a_bubble), .Wait_Timeout(a_to)
`ifdef PIPE_STALL_CNT_EN
    , .Stall_Count(sc_a)
`endif
  );

  pipe_hazard_ctrl #(.FLUSH_CYCLES(1), .MAX_WAIT(4)) u_dut_b (
    .clk(clk), .rst(rst), .IDEX_MemRead(mr), .IDEX_Rt(ex_rt), .IFID_Rs(rs), .IFID_Rt(rt),
    .Branch_Taken(br), .Mem_Busy(busy),
    .PC_WriteEn(b_pc), .IFID_WriteEn(b_ifid), .IDEX_WriteEn(b_idex), .EXMEM_WriteEn(b_exmem),
    .IFID_Flush(b_flush), .IDEX_Bubble(b_bubble), .Wait_Timeout(b_to)
`ifdef PIPE_STALL_CNT_EN
    , .Stall_Count(sc_b)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
  endtask

  // Drive one cycle of inputs just after the edge and queue what it must produce.
  task automatic vec(input string name, input logic sel, input logic r, input logic m,
                     input logic [4:0] xr, input logic [4:0] s, input logic [4:0] t,
                     input logic b, input logic bz, input logic [6:0] exp, input int sc = -1);
    sb_entry_t e;
    @(posedge clk);
    #1;
    rst = r; mr = m; ex_rt = xr; rs = s; rt = t; br = b; busy = bz;
    e.sel = sel; e.exp = exp; e.sc = sc; e.name = name;
    sb_q.push_back(e);
  endtask

  // Monitor: on the falling edge compare the selected instance's outputs.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      if (cur.sel)
        check(cur.name, {25'd0, b_pc, b_ifid, b_idex, b_exmem, b_flush, b_bubble, b_to},
              {25'd0, cur.exp});
      else
        check(cur.name, {25'd0, a_pc, a_ifid, a_idex, a_exmem, a_flush, a_bubble, a_to},
              {25'd0, cur.exp});
`ifdef PIPE_STALL_CNT_EN
      if (cur.sc >= 0 && !cur.sel)
        check({cur.name, "_stall_count"}, {16'd0, sc_a}, cur.sc);
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- instance A: FLUSH_CYCLES=3, MAX_WAIT=5 ----------------
    vec("rst_hold",    0, 0, 0, 0, 0, 0, 0, 0, E_ZERO, 0);
    vec("rst_hold2",   0, 0, 0, 0, 0, 0, 0, 0, E_ZERO, 0);
    vec("run_idle",    0, 1, 0, 0, 0, 0, 0, 0, E_RUN);
    vec("lu_rs",       0, 1, 1, 8, 8, 0, 0, 0, E_LU);
    vec("lu_after",    0, 1, 0, 8, 8, 0, 0, 0, E_RUN);
    vec("lu_rt0",      0, 1, 1, 0, 0, 0, 0, 0, E_RUN);
    vec("lu_rt",       0, 1, 1, 5, 1, 5, 0, 0, E_LU);
    vec("no_memread",  0, 1, 0, 5, 5, 5, 0, 0, E_RUN);
    vec("lu_nomatch",  0, 1, 1, 5, 6, 7, 0, 0, E_RUN);
    // Branch with three flush cycles.
    vec("br_1",        0, 1, 0, 0, 0, 0, 1, 0, E_BR);
    vec("br_2",        0, 1, 0, 0, 0, 0, 0, 0, E_BR);
    vec("br_3",        0, 1, 0, 0, 0, 0, 0, 0, E_BR);
    vec("br_end",      0, 1, 0, 0, 0, 0, 0, 0, E_RUN);
    // Memory stall in the second flush cycle stretches the flush; branch/LU ignored in FLUSH.
    vec("brb_1",       0, 1, 0, 0, 0, 0, 1, 0, E_BR);
    vec("brb_busy",    0, 1, 0, 0, 0, 0, 0, 1, E_ZERO);
    vec("brb_2",       0, 1, 0, 0, 0, 0, 0, 0, E_BR);
    vec("brb_3_ign",   0, 1, 1, 8, 8, 0, 1, 0, E_BR);
    vec("brb_end",     0, 1, 0, 0, 0, 0, 0, 0, E_RUN);
    // Five-cycle memory wait, no timeout.
    vec("rst_pre_wait",0, 0, 0, 0, 0, 0, 0, 0, E_ZERO, 0);
    for (int i = 0; i < 5; i++) vec("wait5", 0, 1, 0, 0, 0, 0, 0, 1, E_ZERO);
    vec("wait5_rel",   0, 1, 0, 0, 0, 0, 0, 0, E_RUN, 5);
    vec("wait5_run",   0, 1, 0, 0, 0, 0, 0, 0, E_RUN, 5);
    // Busy + branch + load-use together: wait first, then branch flush, no LU stall.
    vec("combo_busy",  0, 1, 1, 8, 8, 0, 1, 1, E_ZERO);
    vec("combo_rel",   0, 1, 1, 8, 8, 0, 1, 0, E_BR);
    vec("combo_f2",    0, 1, 0, 0, 0, 0, 0, 0, E_BR);
    vec("combo_f3",    0, 1, 0, 0, 0, 0, 0, 0, E_BR);
    vec("combo_end",   0, 1, 0, 0, 0, 0, 0, 0, E_RUN);
    // Load-use honoured on leaving a memory wait.
    vec("mw_lu_busy",  0, 1, 0, 0, 0, 0, 0, 1, E_ZERO);
    vec("mw_lu_rel",   0, 1, 1, 8, 0, 8, 0, 0, E_LU);
    vec("mw_lu_end",   0, 1, 0, 0, 0, 0, 0, 0, E_RUN);
    // Held busy: five waits allowed, the sixth busy cycle moves to ERROR.
    for (int i = 0; i < 6; i++) vec("to_wait", 0, 1, 0, 0, 0, 0, 0, 1, E_ZERO);
    vec("to_err",      0, 1, 0, 0, 0, 0, 0, 1, E_ERR);
    vec("to_err_idle", 0, 1, 0, 0, 0, 0, 0, 0, E_ERR);
    vec("to_err_br",   0, 1, 0, 0, 0, 0, 1, 0, E_ERR);
    vec("to_rst",      0, 0, 0, 0, 0, 0, 0, 0, E_ZERO, 0);
    vec("to_rel",      0, 1, 0, 0, 0, 0, 0, 0, E_RUN);
    // Reset mid-wait clears the wait counter: five more busy cycles must not time out.
    for (int i = 0; i < 4; i++) vec("mw_pre", 0, 1, 0, 0, 0, 0, 0, 1, E_ZERO);
    vec("mw_rst",      0, 0, 0, 0, 0, 0, 0, 1, E_ZERO, 0);
    for (int i = 0; i < 5; i++) vec("mw_post", 0, 1, 0, 0, 0, 0, 0, 1, E_ZERO);
    vec("mw_rst_rel",  0, 1, 0, 0, 0, 0, 0, 0, E_RUN);
    // Reset mid-flush abandons the flush.
    vec("fr_br",       0, 1, 0, 0, 0, 0, 1, 0, E_BR);
    vec("fr_rst",      0, 0, 0, 0, 0, 0, 0, 0, E_ZERO, 0);
    vec("fr_rel",      0, 1, 0, 0, 0, 0, 0, 0, E_RUN);

    // ---------------- instance B: FLUSH_CYCLES=1, MAX_WAIT=4 ----------------
    vec("b_rst",       1, 0, 0, 0, 0, 0, 0, 0, E_ZERO);
    vec("b_br",        1, 1, 0, 0, 0, 0, 1, 0, E_BR);
    vec("b_br_end",    1, 1, 0, 0, 0, 0, 0, 0, E_RUN);
    for (int i = 0; i < 5; i++) vec("b_wait", 1, 1, 0, 0, 0, 0, 0, 1, E_ZERO);
    vec("b_err",       1, 1, 0, 0, 0, 0, 0, 1, E_ERR);
    vec("b_err_idle",  1, 1, 0, 0, 0, 0, 0, 0, E_ERR);
    vec("b_rst2",      1, 0, 0, 0, 0, 0, 0, 0, E_ZERO);
    vec("b_run",       1, 1, 0, 0, 0, 0, 0, 0, E_RUN);

    @(negedge clk);
    #1;
    check("scoreboard_drain", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
